// File: rtl/crc32_serial_checker.sv
// Receive-side bit-serial CRC32 checker: recomputes CRC over the payload of a
// framed serial stream, compares it with the trailing 32-bit FCS and keeps statistics.
module crc32_serial_checker #(
    parameter logic [31:0] Init_Value = 32'hFFFF_FFFF,
    parameter int          MAX_BITS   = 12144
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        DATA_VALID,
    input  logic        DATA_Serial_Stream,
    input  logic        FRAME_SOF,
    input  logic        FRAME_EOF,
    output logic        BUSY,
    output logic        CHECK_DONE,
    output logic        CRC_OK,
    output logic        CRC_ERR,
    output logic        LEN_ERR,
    output logic [31:0] RX_FCS,
    output logic [31:0] CALC_CRC,
    output logic [15:0] FRAME_BITS,
    output logic [15:0] GOOD_CNT,
    output logic [15:0] BAD_CNT
);

    localparam logic [31:0] POLY       = 32'h04C11DB7;
    localparam logic [15:0] MAX_BITS_W = 16'(MAX_BITS);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_sr, r_lfsr;
    logic [15:0] r_cnt;
    logic        r_crc_ok, r_crc_err, r_len_err;
    logic [31:0] r_rx_fcs, r_calc_crc;
    logic [15:0] r_frame_bits, r_good_cnt, r_bad_cnt;

    logic [31:0] w_sr_shift, w_lfsr_shift;
    logic [15:0] w_total;
    logic        w_start, w_one_bit, w_abort, w_end_normal, w_len_bad, w_match;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic d);
        logic fb;
        fb = crc[31] ^ d;
        return {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    always_comb begin
        w_start      = DATA_VALID && FRAME_SOF;
        w_one_bit    = DATA_VALID && FRAME_SOF && FRAME_EOF;
        w_abort      = (r_state == S_RECV) && DATA_VALID && FRAME_SOF;
        w_end_normal = (r_state == S_RECV) && DATA_VALID && FRAME_EOF && !FRAME_SOF;
        w_sr_shift   = {r_sr[30:0], DATA_Serial_Stream};
        // The 32-bit delay line keeps the FCS out of the LFSR
        w_lfsr_shift = (r_cnt >= 16'd32) ? crc_step(r_lfsr, r_sr[31]) : r_lfsr;
        w_total      = sat_inc(r_cnt);
        w_len_bad    = (w_total < 16'd40) || (w_total[2:0] != 3'd0) || (w_total > MAX_BITS_W);
        w_match      = (w_sr_shift == w_lfsr_shift);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = FRAME_EOF ? S_DONE : S_RECV;
            S_RECV: if (DATA_VALID && (FRAME_SOF || FRAME_EOF))
                        w_state_nxt = FRAME_EOF ? S_DONE : S_RECV;
            S_DONE: w_state_nxt = w_start ? (FRAME_EOF ? S_DONE : S_RECV) : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (w_start) begin
            r_sr   <= {31'b0, DATA_Serial_Stream};
            r_lfsr <= Init_Value;
            r_cnt  <= 16'd1;
        end else if (r_state == S_RECV && DATA_VALID) begin
            r_sr   <= w_sr_shift;
            r_lfsr <= w_lfsr_shift;
            r_cnt  <= w_total;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_crc_ok     <= 1'b0;
            r_crc_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_rx_fcs     <= 32'h0;
            r_calc_crc   <= Init_Value;
            r_frame_bits <= 16'h0;
        end else if (w_one_bit) begin
            r_crc_ok     <= 1'b0;
            r_crc_err    <= 1'b0;
            r_len_err    <= 1'b1;
            r_rx_fcs     <= {31'b0, DATA_Serial_Stream};
            r_calc_crc   <= Init_Value;
            r_frame_bits <= 16'd1;
        end else if (w_end_normal) begin
            r_crc_ok     <= !w_len_bad && w_match;
            r_crc_err    <= !w_len_bad && !w_match;
            r_len_err    <= w_len_bad;
            r_rx_fcs     <= w_sr_shift;
            r_calc_crc   <= w_lfsr_shift;
            r_frame_bits <= w_total;
        end else if (w_start) begin
            r_crc_ok     <= 1'b0;
            r_crc_err    <= 1'b0;
            r_len_err    <= 1'b0;
        end
    end

    // Statistics settle one cycle after CHECK_DONE; aborts count immediately
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_good_cnt <= 16'h0;
            r_bad_cnt  <= 16'h0;
        end else begin
            if (r_state == S_DONE && r_crc_ok)
                r_good_cnt <= sat_inc(r_good_cnt);
            if ((r_state == S_DONE && !r_crc_ok) || w_abort)
                r_bad_cnt <= sat_inc(r_bad_cnt);
        end
    end

    assign BUSY       = (r_state != S_IDLE);
    assign CHECK_DONE = (r_state == S_DONE);
    assign CRC_OK     = r_crc_ok;
    assign CRC_ERR    = r_crc_err;
    assign LEN_ERR    = r_len_err;
    assign RX_FCS     = r_rx_fcs;
    assign CALC_CRC   = r_calc_crc;
    assign FRAME_BITS = r_frame_bits;
    assign GOOD_CNT   = r_good_cnt;
    assign BAD_CNT    = r_bad_cnt;

endmodule

// File: tb/tb_crc32_serial_checker.sv
// Directed bench for crc32_serial_checker: known "123456789" CRC32/MPEG-2 frame,
// corrupted FCS, length violations, abort, back-to-back, reset and saturation.
module tb_crc32_serial_checker;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        DATA_VALID, DATA_Serial_Stream, FRAME_SOF, FRAME_EOF;
    logic        BUSY, CHECK_DONE, CRC_OK, CRC_ERR, LEN_ERR;
    logic [31:0] RX_FCS, CALC_CRC;
    logic [15:0] FRAME_BITS, GOOD_CNT, BAD_CNT;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int done_ref;
    bit frm[$];

    crc32_serial_checker dut (
        .CLK                (CLK),
        .RSTn               (RSTn),
        .DATA_VALID         (DATA_VALID),
        .DATA_Serial_Stream (DATA_Serial_Stream),
        .FRAME_SOF          (FRAME_SOF),
        .FRAME_EOF          (FRAME_EOF),
        .BUSY               (BUSY),
        .CHECK_DONE         (CHECK_DONE),
        .CRC_OK             (CRC_OK),
        .CRC_ERR            (CRC_ERR),
        .LEN_ERR            (LEN_ERR),
        .RX_FCS             (RX_FCS),
        .CALC_CRC           (CALC_CRC),
        .FRAME_BITS         (FRAME_BITS),
        .GOOD_CNT           (GOOD_CNT),
        .BAD_CNT            (BAD_CNT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (CHECK_DONE === 1'b1) n_done++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic build_good(input logic [31:0] fcs);
        logic [7:0] byte_v;
        frm.delete();
        for (int b = 0; b < 9; b++) begin
            byte_v = 8'h31 + 8'(b);
            for (int j = 7; j >= 0; j--) frm.push_back(byte_v[j]);
        end
        for (int j = 31; j >= 0; j--) frm.push_back(fcs[j]);
    endtask

    task automatic build_len(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back((i % 3) == 0);
    endtask

    task automatic drive_bits(input bit sof, input bit eof, input bit gaps);
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps) begin
                DATA_VALID = 1'b0; FRAME_SOF = 1'b0; FRAME_EOF = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            DATA_VALID         = 1'b1;
            DATA_Serial_Stream = frm[i];
            FRAME_SOF          = sof && (i == 0);
            FRAME_EOF          = eof && (i == frm.size() - 1);
            step();
        end
        DATA_VALID = 1'b0; FRAME_SOF = 1'b0; FRAME_EOF = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_busy"},  32'(BUSY),       32'd0);
        chk({pfx, "_done"},  32'(CHECK_DONE), 32'd0);
        chk({pfx, "_ok"},    32'(CRC_OK),     32'd0);
        chk({pfx, "_err"},   32'(CRC_ERR),    32'd0);
        chk({pfx, "_len"},   32'(LEN_ERR),    32'd0);
        chk({pfx, "_fcs"},   RX_FCS,          32'h0);
        chk({pfx, "_calc"},  CALC_CRC,        32'hFFFF_FFFF);
        chk({pfx, "_bits"},  32'(FRAME_BITS), 32'd0);
        chk({pfx, "_good"},  32'(GOOD_CNT),   32'd0);
        chk({pfx, "_bad"},   32'(BAD_CNT),    32'd0);
    endtask

    task automatic check_len_frame(input string tag, input int n, input logic [15:0] bad_exp);
        build_len(n);
        drive_bits(1'b1, 1'b1, 1'b0);
        chk({tag, "_done"}, 32'(CHECK_DONE), 32'd1);
        chk({tag, "_len"},  32'(LEN_ERR),    32'd1);
        chk({tag, "_ok"},   32'(CRC_OK),     32'd0);
        chk({tag, "_err"},  32'(CRC_ERR),    32'd0);
        chk({tag, "_bits"}, 32'(FRAME_BITS), 32'(n));
        step();
        chk({tag, "_bad"},  32'(BAD_CNT),    32'(bad_exp));
    endtask

    initial begin
        RSTn = 1'b0; DATA_VALID = 1'b0; DATA_Serial_Stream = 1'b0;
        FRAME_SOF = 1'b0; FRAME_EOF = 1'b0;
        repeat (3) step();
        check_reset_vals("rst");
        RSTn = 1'b1;
        step();

        // good frame, continuous
        build_good(32'h0376E6E7);
        done_ref = n_done;
        drive_bits(1'b1, 1'b1, 1'b0);
        chk("good_done",  32'(CHECK_DONE), 32'd1);
        chk("good_busy",  32'(BUSY),       32'd1);
        chk("good_ok",    32'(CRC_OK),     32'd1);
        chk("good_err",   32'(CRC_ERR),    32'd0);
        chk("good_len",   32'(LEN_ERR),    32'd0);
        chk("good_calc",  CALC_CRC,        32'h0376E6E7);
        chk("good_fcs",   RX_FCS,          32'h0376E6E7);
        chk("good_bits",  32'(FRAME_BITS), 32'd104);
        step();
        chk("good_pulse", 32'(CHECK_DONE), 32'd0);
        chk("good_idle",  32'(BUSY),       32'd0);
        chk("good_cnt",   32'(GOOD_CNT),   32'd1);
        chk("good_ndone", 32'(n_done - done_ref), 32'd1);

        // corrupted last FCS bit, with valid gaps
        build_good(32'h0376E6E6);
        drive_bits(1'b1, 1'b1, 1'b1);
        chk("bad_done", 32'(CHECK_DONE), 32'd1);
        chk("bad_err",  32'(CRC_ERR),    32'd1);
        chk("bad_ok",   32'(CRC_OK),     32'd0);
        chk("bad_len",  32'(LEN_ERR),    32'd0);
        chk("bad_fcs",  RX_FCS,          32'h0376E6E6);
        chk("bad_calc", CALC_CRC,        32'h0376E6E7);
        step();
        chk("bad_cnt",  32'(BAD_CNT),    32'd1);
        chk("bad_good", 32'(GOOD_CNT),   32'd1);

        // length violations
        check_len_frame("len36", 36, 16'd2);
        check_len_frame("len43", 43, 16'd3);
        check_len_frame("len1",  1,  16'd4);

        // abort after 50 bits, then good frame whose SOF aborts
        done_ref = n_done;
        build_len(50);
        drive_bits(1'b1, 1'b0, 1'b0);
        chk("abort_busy", 32'(BUSY), 32'd1);
        build_good(32'h0376E6E7);
        drive_bits(1'b1, 1'b1, 1'b0);
        chk("abort_ok",   32'(CRC_OK), 32'd1);
        step();
        chk("abort_bad",   32'(BAD_CNT),  32'd5);
        chk("abort_good",  32'(GOOD_CNT), 32'd2);
        chk("abort_ndone", 32'(n_done - done_ref), 32'd1);

        // back-to-back: second SOF lands in the DONE cycle
        done_ref = n_done;
        drive_bits(1'b1, 1'b1, 1'b0);
        drive_bits(1'b1, 1'b1, 1'b0);
        chk("b2b_done", 32'(CHECK_DONE), 32'd1);
        chk("b2b_ok",   32'(CRC_OK),     32'd1);
        step();
        chk("b2b_good",  32'(GOOD_CNT), 32'd4);
        chk("b2b_ndone", 32'(n_done - done_ref), 32'd2);

        // reset in the middle of a frame
        build_len(60);
        drive_bits(1'b1, 1'b0, 1'b0);
        RSTn = 1'b0;
        step();
        check_reset_vals("mrst");
        RSTn = 1'b1;
        step();
        build_good(32'h0376E6E7);
        drive_bits(1'b1, 1'b1, 1'b0);
        chk("mrst_ok", 32'(CRC_OK), 32'd1);
        step();
        chk("mrst_good", 32'(GOOD_CNT), 32'd1);

        // saturation of GOOD_CNT
        force dut.r_good_cnt = 16'hFFFE;
        step();
        release dut.r_good_cnt;
        step();
        drive_bits(1'b1, 1'b1, 1'b0);
        step();
        chk("sat_good1", 32'(GOOD_CNT), 32'h0000_FFFF);
        drive_bits(1'b1, 1'b1, 1'b0);
        step();
        chk("sat_good2", 32'(GOOD_CNT), 32'h0000_FFFF);

        // over-length frame
        check_len_frame("lenmax", 12144 + 8, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
